// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, legal-opcode check and FSM encoding for alu_rr_scheduler
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: is_legal_op = 1'b1;
      default:                        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - 2-way round-robin winner select; the pointer requester wins ties
module rr_arbiter2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant,
  output logic       o_idx,
  output logic       o_any
);

  always_comb begin
    o_any   = |i_valid;
    o_idx   = i_valid[i_ptr] ? i_ptr : ~i_ptr;
    o_grant = o_any ? (o_idx ? 2'b10 : 2'b01) : 2'b00;
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - shares one ALU between two requesters, round-robin, one transaction at a time
// Optional: ALU_SCHED_ILLEGAL_OP_CHECK_EN answers illegal opcodes directly with result 0 and o_err=1.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_OPCODE   = 6,
  parameter int ALU_LATENCY = 0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [1:0]             i_req_valid,
  input  logic [2*NB_DATA-1:0]   i_req_data_a,
  input  logic [2*NB_DATA-1:0]   i_req_data_b,
  input  logic [2*NB_OPCODE-1:0] i_req_op,
  output logic [1:0]             o_req_ready,
  output logic [NB_DATA-1:0]     o_alu_data_a,
  output logic [NB_DATA-1:0]     o_alu_data_b,
  output logic [NB_OPCODE-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0]     i_alu_result,
  output logic [1:0]             o_rsp_valid,
  output logic [NB_DATA-1:0]     o_rsp_result,
  input  logic [1:0]             i_rsp_ready,
  output logic                   o_busy,
  output logic                   o_err
);

  state_e               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic                 g_q, g_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [NB_DATA-1:0]   a_q, a_d;
  logic [NB_DATA-1:0]   b_q, b_d;
  logic [NB_OPCODE-1:0] op_q, op_d;
  logic [NB_DATA-1:0]   res_q, res_d;
`ifdef ALU_SCHED_ILLEGAL_OP_CHECK_EN
  logic                 err_q, err_d;
`endif

  logic [1:0]           arb_grant;
  logic                 arb_idx;
  logic                 arb_any;
  logic [NB_OPCODE-1:0] sel_op;

  rr_arbiter2 u_arb (
    .i_valid (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (arb_grant),
    .o_idx   (arb_idx),
    .o_any   (arb_any)
  );

  assign sel_op = arb_idx ? i_req_op[NB_OPCODE +: NB_OPCODE] : i_req_op[0 +: NB_OPCODE];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      g_q     <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
`ifdef ALU_SCHED_ILLEGAL_OP_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
`ifdef ALU_SCHED_ILLEGAL_OP_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
`ifdef ALU_SCHED_ILLEGAL_OP_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          a_d     = arb_idx ? i_req_data_a[NB_DATA +: NB_DATA] : i_req_data_a[0 +: NB_DATA];
          b_d     = arb_idx ? i_req_data_b[NB_DATA +: NB_DATA] : i_req_data_b[0 +: NB_DATA];
          op_d    = sel_op;
          g_d     = arb_idx;
          cnt_d   = 4'(ALU_LATENCY);
          state_d = ST_EXEC;
`ifdef ALU_SCHED_ILLEGAL_OP_CHECK_EN
          // Illegal opcodes never reach the ALU result path.
          if (!is_legal_op(6'(sel_op))) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
          end
`endif
        end
      end
      ST_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d   = i_alu_result;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready[g_q]) begin
          ptr_d   = ~g_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready  = (state_q == ST_IDLE) ? arb_grant : 2'b00;
    o_rsp_valid  = (state_q == ST_RESP) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
    o_busy       = (state_q != ST_IDLE);
    o_alu_data_a = a_q;
    o_alu_data_b = b_q;
    o_alu_op     = op_q;
    o_rsp_result = res_q;
`ifdef ALU_SCHED_ILLEGAL_OP_CHECK_EN
    o_err        = err_q;
`else
    o_err        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - directed self-checking bench for alu_rr_scheduler (latency 0 and 3)
module tb_alu_rr_scheduler;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] NOR = 6'b100111;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [1:0]  i_req_valid;
  logic [15:0] i_req_data_a;
  logic [15:0] i_req_data_b;
  logic [11:0] i_req_op;
  logic [1:0]  i_rsp_ready;

  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  alu_a, alu_b, alu_res, rsp_result;
  logic [5:0]  alu_op;
  logic        busy, err;

  logic [1:0]  req_ready3, rsp_valid3;
  logic [7:0]  alu_a3, alu_b3, alu_res3, rsp_result3;
  logic [5:0]  alu_op3;
  logic        busy3, err3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      ADD:     alu_model = a + b;
      SUB:     alu_model = a - b;
      AND:     alu_model = a & b;
      OR:      alu_model = a | b;
      XOR:     alu_model = a ^ b;
      SRA:     alu_model = $unsigned($signed(a) >>> b[2:0]);
      SRL:     alu_model = a >> b[2:0];
      NOR:     alu_model = ~(a | b);
      default: alu_model = a ^ b;
    endcase
  endfunction

  assign alu_res  = alu_model(alu_a, alu_b, alu_op);
  assign alu_res3 = alu_model(alu_a3, alu_b3, alu_op3);

  alu_rr_scheduler #(.NB_DATA(8), .NB_OPCODE(6), .ALU_LATENCY(0)) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .i_req_data_a (i_req_data_a),
    .i_req_data_b (i_req_data_b),
    .i_req_op     (i_req_op),
    .o_req_ready  (req_ready),
    .o_alu_data_a (alu_a),
    .o_alu_data_b (alu_b),
    .o_alu_op     (alu_op),
    .i_alu_result (alu_res),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_result (rsp_result),
    .i_rsp_ready  (i_rsp_ready),
    .o_busy       (busy),
    .o_err        (err)
  );

  alu_rr_scheduler #(.NB_DATA(8), .NB_OPCODE(6), .ALU_LATENCY(3)) dut3 (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .i_req_data_a (i_req_data_a),
    .i_req_data_b (i_req_data_b),
    .i_req_op     (i_req_op),
    .o_req_ready  (req_ready3),
    .o_alu_data_a (alu_a3),
    .o_alu_data_b (alu_b3),
    .o_alu_op     (alu_op3),
    .i_alu_result (alu_res3),
    .o_rsp_valid  (rsp_valid3),
    .o_rsp_result (rsp_result3),
    .i_rsp_ready  (i_rsp_ready),
    .o_busy       (busy3),
    .o_err        (err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset      = 1'b1;
    i_req_valid  = 2'b00;
    i_req_data_a = '0;
    i_req_data_b = '0;
    i_req_op     = '0;
    i_rsp_ready  = 2'b00;
    step();
    step();
    i_reset = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    i_req_data_a[k*8 +: 8] = a;
    i_req_data_b[k*8 +: 8] = b;
    i_req_op[k*6 +: 6]     = op;
  endtask

  // One latency-0 transaction on dut, starting in an IDLE cycle with requests already driven.
  task automatic serve(input string tag, input logic [1:0] exp_gnt, input logic [7:0] exp_res, input bit drop);
    #1;
    check({tag, "_gnt"}, req_ready, exp_gnt);
    step();
    if (drop) i_req_valid = i_req_valid & ~exp_gnt;
    check({tag, "_exec_busy_rdy"}, {busy, req_ready, rsp_valid}, 5'b1_00_00);
    step();
    check({tag, "_rsp_valid"}, rsp_valid, exp_gnt);
    check({tag, "_rsp_result"}, rsp_result, exp_res);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_resp_no_rdy"}, req_ready, 2'b00);
    i_rsp_ready = exp_gnt;
    step();
    i_rsp_ready = 2'b00;
  endtask

  initial begin
    logic [1:0] g;

    // Reset state
    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_alu_regs", {alu_a, alu_b, alu_op}, 22'h0);
    check("rst_result_err", {rsp_result, err}, 9'h0);

    // 1: single requester ADD
    set_req(0, 8'h05, 8'h03, ADD);
    i_req_valid = 2'b01;
    serve("t1", 2'b01, 8'h08, 1'b1);
    check("t1_idle_after", busy, 1'b0);

    // 2: simultaneous requests right after reset, pointer 0 first
    do_reset();
    set_req(0, 8'h10, 8'h01, SUB);
    set_req(1, 8'hF0, 8'h3C, AND);
    i_req_valid = 2'b11;
    serve("t2_req0", 2'b01, 8'h0F, 1'b1);
    serve("t2_req1", 2'b10, 8'h30, 1'b1);

    // 3: continuous contention alternates 0,1,0,1
    do_reset();
    set_req(0, 8'h05, 8'h03, ADD);
    set_req(1, 8'h09, 8'h04, SUB);
    i_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 2'b01 : 2'b10;
      serve($sformatf("t3_txn%0d", k), g, (k % 2 == 0) ? 8'h08 : 8'h05, 1'b0);
    end
    i_req_valid = 2'b00;

    // 4: response backpressure; non-granted ready and a new request are ignored
    do_reset();
    set_req(0, 8'hA0, 8'h0F, OR);
    i_req_valid = 2'b01;
    #1;
    check("t4_gnt", req_ready, 2'b01);
    step();
    i_req_valid = 2'b00;
    step();
    set_req(1, 8'h01, 8'h01, ADD);
    i_req_valid = 2'b10;
    i_rsp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("t4_hold%0d", c), {rsp_valid, rsp_result, busy, req_ready}, {2'b01, 8'hAF, 1'b1, 2'b00});
      step();
    end
    i_rsp_ready = 2'b01;
    step();
    i_rsp_ready = 2'b00;
    check("t4_release_idle", busy, 1'b0);
    i_req_valid = 2'b00;

    // 5: latency-3 instance reset in its second EXEC cycle
    do_reset();
    set_req(0, 8'h05, 8'h03, ADD);
    i_req_valid = 2'b01;
    #1;
    check("t5_gnt", req_ready3, 2'b01);
    step();
    i_req_valid = 2'b00;
    check("t5_exec1_busy", busy3, 1'b1);
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("t5_after_reset", {busy3, rsp_valid3, req_ready3, alu_a3, alu_b3, alu_op3, rsp_result3, err3},
          40'h0);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("t5_no_rsp%0d", c), rsp_valid3, 2'b00);
      step();
    end
    set_req(1, 8'h01, 8'h02, ADD);
    i_req_valid = 2'b11;
    #1;
    check("t5_ptr0_wins", req_ready3, 2'b01);
    step();
    i_req_valid = 2'b00;
    // Latency 3: accept in cycle 0, first response in cycle 5
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("t5_lat_c%0d", c), rsp_valid3, (c == 5) ? 2'b01 : 2'b00);
      if (c < 5) step();
    end
    check("t5_lat_result", rsp_result3, 8'h08);

    // 6: opcode 111111
    do_reset();
    set_req(0, 8'h12, 8'h34, 6'b111111);
    i_req_valid = 2'b01;
    #1;
    check("t6_gnt", req_ready, 2'b01);
    step();
    i_req_valid = 2'b00;
`ifdef ALU_SCHED_ILLEGAL_OP_CHECK_EN
    check("t6_rsp_valid", rsp_valid, 2'b01);
    check("t6_result", rsp_result, 8'h00);
    check("t6_err", err, 1'b1);
`else
    check("t6_exec_no_rsp", rsp_valid, 2'b00);
    step();
    check("t6_rsp_valid", rsp_valid, 2'b01);
    check("t6_result", rsp_result, 8'h26);
    check("t6_err", err, 1'b0);
`endif
    i_rsp_ready = 2'b01;
    step();
    i_rsp_ready = 2'b00;
    check("t6_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
